axi_rd_arbiter: RTL

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter_if.sv | 56 +++++
 rtl/axi_rd_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter_if.sv
// Bundle of the requester-side and manager-side AXI read channels seen by
// axi_rd_arbiter. Requester-side vectors are packed, with requester i at slice i.
interface axi_rd_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) ();

  // requester-side AR channel
  logic [N_REQ-1:0]        s_arvalid;
  logic [N_REQ-1:0]        s_arready;
  logic [N_REQ*ADDR_W-1:0] s_araddr;
  logic [N_REQ*ID_W-1:0]   s_arid;
  logic [N_REQ*8-1:0]      s_arlen;

  // requester-side R channel (payload broadcast, valid/ready per requester)
  logic [N_REQ-1:0]        s_rvalid;
  logic [N_REQ-1:0]        s_rready;
  logic [DATA_W-1:0]       s_rdata;
  logic [ID_W-1:0]         s_rid;
  logic [1:0]              s_rresp;
  logic                    s_rlast;

  // manager-side AR channel
  logic                    m_arvalid;
  logic                    m_arready;
  logic [ADDR_W-1:0]       m_araddr;
  logic [ID_W-1:0]         m_arid;
  logic [7:0]              m_arlen;

  // manager-side R channel
  logic                    m_rvalid;
  logic                    m_rready;
  logic [DATA_W-1:0]       m_rdata;
  logic [ID_W-1:0]         m_rid;
  logic [1:0]              m_rresp;
  logic                    m_rlast;

  // arbiter view
  modport slave (
    input  s_arvalid, s_araddr, s_arid, s_arlen, s_rready,
    output s_arready, s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
    output m_arvalid, m_araddr, m_arid, m_arlen, m_rready,
    input  m_arready, m_rvalid, m_rdata, m_rid, m_rresp, m_rlast
  );

  // environment view (requesters and manager together)
  modport master (
    output s_arvalid, s_araddr, s_arid, s_arlen, s_rready,
    input  s_arready, s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
    input  m_arvalid, m_araddr, m_arid, m_arlen, m_rready,
    output m_arready, m_rvalid, m_rdata, m_rid, m_rresp, m_rlast
  );

endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read manager port between N_REQ
// requesters. One burst is outstanding at a time: the winner's AR request is
// forwarded combinationally, then its R beats are routed back to it until the
// manager signals rlast. Burst length violations raise a sticky len_err.
module axi_rd_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  axi_rd_arbiter_if.slave          bus,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     busy,
  output logic                     len_err
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [GW-1:0] grant_r;
  logic [GW-1:0] last_grant_r;
  logic [GW-1:0] grant_next_s;
  logic [7:0]    arlen_r;
  logic [8:0]    beat_r;
  logic          len_err_r;
  logic          ar_fire_s;
  logic          r_fire_s;
  logic          len_bad_s;
  logic [7:0]    arlen_sel_s;

  // Rotating-priority search: first set request after 'last', wrapping round.
  function automatic logic [GW-1:0] pick_next(input logic [N_REQ-1:0] req,
                                               input logic [GW-1:0]    last);
    logic [GW-1:0] sel;
    logic          found;
    logic          hit;
    int            idx;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx   = (int'(last) + k) % N_REQ;
      hit   = !found && req[idx];
      sel   = hit ? GW'(idx) : sel;
      found = found | hit;
    end
    return sel;
  endfunction

  assign grant_next_s = pick_next(bus.s_arvalid, last_grant_r);
  assign arlen_sel_s  = bus.s_arlen[int'(grant_r)*8 +: 8];

  // Next-state logic and handshake routing to/from the granted requester only.
  always_comb begin
    state_s       = state_r;
    bus.s_arready = '0;
    bus.s_rvalid  = '0;
    bus.m_arvalid = 1'b0;
    bus.m_rready  = 1'b0;
    ar_fire_s     = 1'b0;
    r_fire_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|bus.s_arvalid) begin
          state_s = ST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        bus.m_arvalid          = bus.s_arvalid[grant_r];
        bus.s_arready[grant_r] = bus.m_arready;
        ar_fire_s              = bus.s_arvalid[grant_r] && bus.m_arready;
        if (ar_fire_s) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        bus.s_rvalid[grant_r] = bus.m_rvalid;
        bus.m_rready          = bus.s_rready[grant_r];
        r_fire_s              = bus.m_rvalid && bus.s_rready[grant_r];
        if (r_fire_s && bus.m_rlast) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DATA;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // AR payload mirrors the granted requester; only m_arvalid is state-gated.
  always_comb begin
    bus.m_araddr = bus.s_araddr[int'(grant_r)*ADDR_W +: ADDR_W];
    bus.m_arid   = bus.s_arid[int'(grant_r)*ID_W +: ID_W];
    bus.m_arlen  = arlen_sel_s;
  end

  // R payload is broadcast unregistered; only s_rvalid selects the receiver.
  always_comb begin
    bus.s_rdata = bus.m_rdata[DATA_W-1:0];
    bus.s_rid   = bus.m_rid;
    bus.s_rresp = bus.m_rresp;
    bus.s_rlast = bus.m_rlast;
  end

  // A beat is wrong if rlast arrives off the expected count, or the expected
  // last beat arrives without rlast. beat_r counts beats already accepted.
  always_comb begin
    if (r_fire_s) begin
      if (bus.m_rlast) begin
        len_bad_s = (beat_r != {1'b0, arlen_r});
      end else begin
        len_bad_s = (beat_r == {1'b0, arlen_r});
      end
    end else begin
      len_bad_s = 1'b0;
    end
  end

  // FSM state register; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant is latched when leaving IDLE; priority rotates when a burst ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r      <= '0;
      last_grant_r <= GW'(N_REQ - 1);
    end else begin
      if (state_r == ST_IDLE && |bus.s_arvalid) begin
        grant_r <= grant_next_s;
      end else begin
        grant_r <= grant_r;
      end
      if (r_fire_s && bus.m_rlast) begin
        last_grant_r <= grant_r;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  // Burst length capture on AR handshake and beat counting on R handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      arlen_r <= 8'd0;
      beat_r  <= 9'd0;
    end else if (ar_fire_s) begin
      arlen_r <= arlen_sel_s;
      beat_r  <= 9'd0;
    end else if (r_fire_s) begin
      arlen_r <= arlen_r;
      beat_r  <= beat_r + 9'd1;
    end else begin
      arlen_r <= arlen_r;
      beat_r  <= beat_r;
    end
  end

  // Sticky length-violation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_err_r <= 1'b0;
    end else if (len_bad_s) begin
      len_err_r <= 1'b1;
    end else begin
      len_err_r <= len_err_r;
    end
  end

  assign grant_idx = grant_r;
  assign busy      = (state_r != ST_IDLE);
  assign len_err   = len_err_r;

endmodule
